// File: rtl/rgb_led_pwm.sv
// Twelve-channel PWM dimmer for the four RGB LEDs. Duties are staged through a
// valid/ready write port and swapped into the active set only at a period boundary.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// ST_IDLE    | no commit outstanding, staging writes accepted
// ST_PENDING | commit requested, waiting for period end, writes stalled
module rgb_led_pwm #(
    parameter int PWM_WIDTH = 8,
    parameter int PRESCALE  = 4
) (
    input  logic                 clk_100mhz,
    input  logic                 rst,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [3:0]           wr_addr,
    input  logic [PWM_WIDTH-1:0] wr_data,
    input  logic                 commit,
    output logic                 commit_pending,
    output logic                 frame_start,
    output logic [11:0]          led_rgb
);

    localparam int NUM_CH = 12;
    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0]     PRE_MAX    = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_WIDTH-1:0] CNT_MAX    = PWM_WIDTH'((2 ** PWM_WIDTH) - 2);
    localparam logic [3:0]           ADDR_LIMIT = 4'd12;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } state_t;

    state_t state, state_next;

    logic [PRE_W-1:0]     pre;
    logic [PWM_WIDTH-1:0] cnt;
    logic                 tick;
    logic                 period_end;
    logic                 load_active;
    logic                 wr_fire;

    logic [PWM_WIDTH-1:0] staging [NUM_CH];
    logic [PWM_WIDTH-1:0] active  [NUM_CH];

    assign tick       = (pre == PRE_MAX);
    assign period_end = tick && (cnt == CNT_MAX);
    assign wr_fire    = wr_valid && wr_ready;

    // Period is 2^W-1 ticks so that a full-scale duty (2^W-1) reads as constant on.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            pre <= '0;
            cnt <= '0;
        end else if (tick) begin
            pre <= '0;
            cnt <= period_end ? '0 : cnt + 1'b1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        load_active    = 1'b0;
        wr_ready       = 1'b1;
        commit_pending = 1'b0;
        case (state)
            ST_IDLE: begin
                if (commit) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                wr_ready       = 1'b0;
                commit_pending = 1'b1;
                if (period_end) begin
                    load_active = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Out-of-range addresses still complete the handshake; the data is dropped.
    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                staging[i] <= '0;
                active[i]  <= '0;
            end
        end else begin
            if (wr_fire && (wr_addr < ADDR_LIMIT)) begin
                staging[wr_addr] <= wr_data;
            end
            if (load_active) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    active[i] <= staging[i];
                end
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        if (rst) begin
            led_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= period_end;
            for (int i = 0; i < NUM_CH; i++) begin
                led_rgb[i] <= (cnt < active[i]);
            end
        end
    end

endmodule
